// File: rtl/reg_file.sv
// reg_file: 32x32 integer register file, two async reads, one write.
// State updates on the falling clock edge; x0 is hardwired to zero.
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        we3,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [4:0]  a3,
  input  logic [31:0] wd3,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_q [31:1];
  logic [31:0] regs_d [31:1];

  always_comb begin
    regs_d = regs_q;
    if (we3 && (a3 != 5'd0)) begin
      regs_d[a3] = wd3;
    end
  end

  // Mid-cycle commit lets decode see writeback data in the same cycle.
  always_ff @(negedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (a1 != 5'd0) rd1 = regs_q[a1];
    if (a2 != 5'd0) rd2 = regs_q[a2];
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vectors for reg_file.
// Inputs change after the rising edge; writes commit on the falling edge.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        we3;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int total;
  int bad;

  reg_file u_dut (
    .clk   (clk),
    .reset (reset),
    .we3   (we3),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic fall();
    @(negedge clk);
    #1;
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rise();
    reset = 1'b0;
    we3   = 1'b1;
    a3    = a;
    wd3   = d;
    fall();
    we3   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    we3   = 1'b0;
    a1    = 5'd0;
    a2    = 5'd0;
    a3    = 5'd0;
    wd3   = '0;

    // x0 reads zero even before reset
    #1;
    chk("x0_prereset_rd1", rd1, 32'h0);

    fall();
    for (int i = 1; i < 32; i += 6) begin
      a1 = 5'(i);
      a2 = 5'(31 - i);
      #1;
      chk("rst_rd1", rd1, 32'h0);
      chk("rst_rd2", rd2, 32'h0);
    end

    // reset clear
    wr(5'd7, 32'hDEADBEEF);
    a1 = 5'd7;
    #1;
    chk("x7_written", rd1, 32'hDEADBEEF);
    rise();
    reset = 1'b1;
    fall();
    reset = 1'b0;
    a1 = 5'd7;
    a2 = 5'd31;
    #1;
    chk("clr_rd1", rd1, 32'h0);
    chk("clr_rd2", rd2, 32'h0);

    // basic write/read
    wr(5'd5, 32'hA5A5A5A5);
    a1 = 5'd5;
    a2 = 5'd5;
    #1;
    chk("x5_rd1", rd1, 32'hA5A5A5A5);
    chk("x5_rd2", rd2, 32'hA5A5A5A5);

    // x0 immutability
    wr(5'd0, 32'hFFFFFFFF);
    a1 = 5'd0;
    a2 = 5'd0;
    #1;
    chk("x0_rd1", rd1, 32'h0);
    chk("x0_rd2", rd2, 32'h0);

    // independent ports
    wr(5'd10, 32'h12345678);
    a1 = 5'd5;
    a2 = 5'd10;
    #1;
    chk("ind_rd1", rd1, 32'hA5A5A5A5);
    chk("ind_rd2", rd2, 32'h12345678);

    // same-cycle writeback
    wr(5'd3, 32'h11111111);
    rise();
    a1  = 5'd3;
    a2  = 5'd3;
    we3 = 1'b1;
    a3  = 5'd3;
    wd3 = 32'h22222222;
    #1;
    chk("wb_before", rd1, 32'h11111111);
    fall();
    we3 = 1'b0;
    chk("wb_after_rd1", rd1, 32'h22222222);
    chk("wb_after_rd2", rd2, 32'h22222222);
    rise();
    chk("wb_next_rise", rd1, 32'h22222222);

    // write disabled
    we3 = 1'b0;
    a3  = 5'd5;
    wd3 = 32'h0;
    fall();
    a1 = 5'd5;
    a2 = 5'd10;
    #1;
    chk("we0_x5", rd1, 32'hA5A5A5A5);
    chk("we0_x10", rd2, 32'h12345678);

    // reset beats a write on the same edge
    rise();
    reset = 1'b1;
    we3   = 1'b1;
    a3    = 5'd5;
    wd3   = 32'hCAFEF00D;
    fall();
    a1 = 5'd5;
    a2 = 5'd3;
    #1;
    chk("rstprio_x5", rd1, 32'h0);
    chk("rstprio_x3", rd2, 32'h0);

    // held reset keeps clearing
    fall();
    chk("rsthold_x5", rd1, 32'h0);

    // writes resume once reset drops
    rise();
    reset = 1'b0;
    a3    = 5'd31;
    wd3   = 32'h0BADC0DE;
    fall();
    we3 = 1'b0;
    a1  = 5'd31;
    a2  = 5'd5;
    #1;
    chk("resume_x31", rd1, 32'h0BADC0DE);
    chk("resume_x5", rd2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

32 × 32-bit integer register file for the pipelined RISC-V core: two combinational read ports (decode stage) and one synchronous write port (writeback stage). Writes commit on the falling edge of the clock, so a value written back in a cycle is visible to a decode-stage read later in that same cycle. Register x0 is hardwired to zero.

## Interface
- No parameters. Fixed: 32 registers, 32-bit data, 5-bit addresses.
- clk  input  1  single clock; all state updates occur on its falling edge.
- reset  input  1  synchronous, active-high; sampled on the falling edge of clk.
- we3  input  1  write enable for port 3.
- a1  input  5  read port 1 address.
- a2  input  5  read port 2 address.
- a3  input  5  write port 3 address.
- wd3  input  32  write port 3 data.
- rd1  output  32  read port 1 data, combinational from a1.
- rd2  output  32  read port 2 data, combinational from a2.

## Operation
- Storage: registers x1..x31, 32 bits each. x0 has no storage.
- Read: rd1 = (a1 == 0) ? 0 : reg[a1]; rd2 = (a2 == 0) ? 0 : reg[a2]. Purely combinational, no clock dependency, and no internal bypass beyond the falling-edge write.
- Write: on a falling edge of clk with reset = 0 and we3 = 1, reg[a3] <= wd3 when a3 != 0.
- A write to a3 = 0 is discarded. x0 always reads 0.
- we3 = 0: no register changes.
- Reset: on a falling edge with reset = 1, all of x1..x31 are cleared to 0. Reset overrides any write in the same edge.
- Both read ports may address the same register, or the write target, at the same time. No conflicts and no stalls.
- The design is fully synchronous. There are no X outputs after the first reset. Before any reset, register contents are undefined, except x0, which reads 0.

## Timing
- Read latency: 0 cycles. rd1 and rd2 follow a1, a2 and the register contents combinationally.
- Write latency: the new value is visible on any read port addressing a3 immediately after the falling edge that commits it. That falling edge falls in the middle of the writeback cycle.
- Write and read of the same register in the same cycle: rd shows the old value until the falling edge and the new value after it. A read sampled at the next rising edge gets the new value.
- Reset: takes effect at the first falling edge with reset high. After that edge, rd1 = rd2 = 0 for every address. The clear lasts while reset is held.
- Reset deasserted: writes resume on the next falling edge where reset = 0.
- Outputs have no reset value of their own; they reflect the addressed register, which is 0 after reset.

## Test plan
- Reset clear: write x7 = 0xDEADBEEF, then assert reset for one falling edge, set a1 = 7, a2 = 31 -> rd1 = rd2 = 0x00000000.
- Basic write/read: we3 = 1, a3 = 5, wd3 = 0xA5A5A5A5, one falling edge; then we3 = 0, a1 = a2 = 5 -> rd1 = rd2 = 0xA5A5A5A5.
- x0 immutability: we3 = 1, a3 = 0, wd3 = 0xFFFFFFFF, falling edge; a1 = a2 = 0 -> rd1 = rd2 = 0x00000000.
- Independent ports: write x10 = 0x12345678 after x5 = 0xA5A5A5A5; a1 = 5, a2 = 10 -> rd1 = 0xA5A5A5A5, rd2 = 0x12345678.
- Same-cycle writeback: a1 = 3 holding 0x11111111; we3 = 1, a3 = 3, wd3 = 0x22222222 -> rd1 = 0x11111111 before the falling edge and 0x22222222 after it, within the same cycle.
- Write disabled and reset priority: we3 = 0, a3 = 5, wd3 = 0x0 -> x5 unchanged. Then reset = 1 and we3 = 1, a3 = 5, wd3 = 0xCAFEF00D on the same edge -> x5 reads 0x00000000.
